apb_regfile_slave: RTL

- APB completer sitting directly downstream of apb_emulator; consumes the APB transfers the emulator drives and returns ready/rdata/slverr.
- Provides a bank of byte-strobed 32-bit registers, a read-only status word with transfer/error counters, and a fixed number of wait states per transfer.
- Exports register contents so testbenches and stimc models can observe write effects.

---
 rtl/apb_regfile_slave.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/apb_regfile_slave.sv
// APB completer with a bank of byte-strobed RW registers, a read-only STATUS word
// ({err_cnt, xfer_cnt}) at word index NREGS, and a fixed number of wait states.
// Optional macro APB_REGFILE_SLAVE_PROT_CHECK_EN: unprivileged writes to register 0
// complete with an error and leave the register untouched.
`timescale 1ns/1ps
module apb_regfile_slave #(
  parameter int unsigned         ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]   BASE_ADDR   = '0,
  parameter int unsigned         NREGS       = 8,
  parameter int unsigned         WAIT_STATES = 1
) (
  input  logic                  apb_clk_i,
  input  logic                  apb_resetn_i,
  input  logic [ADDR_W-1:0]     apb_addr_i,
  input  logic                  apb_sel_i,
  input  logic                  apb_enable_i,
  input  logic                  apb_write_i,
  input  logic [3:0]            apb_strb_i,
  input  logic [2:0]            apb_prot_i,
  input  logic [31:0]           apb_wdata_i,
  output logic                  apb_ready_o,
  output logic [31:0]           apb_rdata_o,
  output logic                  apb_slverr_o,
  output logic [NREGS*32-1:0]   regs_o
);

  localparam int unsigned IdxW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              is_reg_q, is_reg_d;
  logic              is_stat_q, is_stat_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              write_q, write_d;
  logic [3:0]        strb_q, strb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              slverr_q, slverr_d;
  logic [15:0]       xfer_cnt_q, xfer_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [31:0]       regs_q [NREGS];
  logic [31:0]       regs_d [NREGS];

  // Address decode of the live bus address (used at the setup edge)
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word;
  logic              live_is_reg, live_is_stat;
  logic [IdxW-1:0]   live_idx;

  // Response inputs: live bus in IDLE (zero-wait response), captured fields in ACCESS
  logic              cur_is_reg, cur_is_stat, cur_write;
  logic [IdxW-1:0]   cur_idx;
  logic              prot_err;
  logic              resp_err;
  logic [31:0]       resp_rdata;

`ifdef APB_REGFILE_SLAVE_PROT_CHECK_EN
  logic [2:0]        prot_q, prot_d;
  logic [2:0]        cur_prot;
`else
  logic              unused_prot;
  assign unused_prot = ^apb_prot_i;
`endif

  // Decode byte address into word index relative to BASE_ADDR
  always_comb begin
    offset       = apb_addr_i - BASE_ADDR;
    word         = offset >> 2;
    live_is_reg  = (apb_addr_i >= BASE_ADDR) && (word < ADDR_W'(NREGS));
    live_is_stat = (apb_addr_i >= BASE_ADDR) && (word == ADDR_W'(NREGS));
    live_idx     = word[IdxW-1:0];
  end

  // Build the response (error flag and read data) for the transfer in flight
  always_comb begin
    if (state_q == StIdle) begin
      cur_is_reg  = live_is_reg;
      cur_is_stat = live_is_stat;
      cur_write   = apb_write_i;
      cur_idx     = live_idx;
    end else begin
      cur_is_reg  = is_reg_q;
      cur_is_stat = is_stat_q;
      cur_write   = write_q;
      cur_idx     = idx_q;
    end
`ifdef APB_REGFILE_SLAVE_PROT_CHECK_EN
    cur_prot = (state_q == StIdle) ? apb_prot_i : prot_q;
    prot_err = cur_write && cur_is_reg && (cur_idx == '0) && !cur_prot[0];
`else
    prot_err = 1'b0;
`endif
    resp_err = (!cur_is_reg && !cur_is_stat) || (cur_write && cur_is_stat) || prot_err;
    resp_rdata = '0;
    if (!cur_write && !resp_err) begin
      resp_rdata = cur_is_stat ? {err_cnt_q, xfer_cnt_q} : regs_q[cur_idx];
    end
  end

  // Transfer FSM: next state, captured fields, response, commit and counters
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    is_reg_d   = is_reg_q;
    is_stat_d  = is_stat_q;
    idx_d      = idx_q;
    write_d    = write_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    ready_d    = 1'b0;
    rdata_d    = '0;
    slverr_d   = 1'b0;
    xfer_cnt_d = xfer_cnt_q;
    err_cnt_d  = err_cnt_q;
    regs_d     = regs_q;
`ifdef APB_REGFILE_SLAVE_PROT_CHECK_EN
    prot_d     = prot_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (apb_sel_i && !apb_enable_i) begin
          is_reg_d   = live_is_reg;
          is_stat_d  = live_is_stat;
          idx_d      = live_idx;
          write_d    = apb_write_i;
          strb_d     = apb_strb_i;
          wdata_d    = apb_wdata_i;
`ifdef APB_REGFILE_SLAVE_PROT_CHECK_EN
          prot_d     = apb_prot_i;
`endif
          wait_cnt_d = 4'(WAIT_STATES);
          state_d    = StAccess;
          if (WAIT_STATES == 0) begin
            ready_d  = 1'b1;
            rdata_d  = resp_rdata;
            slverr_d = resp_err;
          end
        end
      end
      StAccess: begin
        if (!apb_sel_i) begin
          // Aborted transfer: no commit, no counter change
          state_d = StIdle;
        end else if (apb_enable_i && ready_q) begin
          // slverr_q already encodes every reason a write must not land
          if (write_q && !slverr_q) begin
            for (int b = 0; b < 4; b++) begin
              if (strb_q[b]) regs_d[idx_q][8*b +: 8] = wdata_q[8*b +: 8];
            end
          end
          if (xfer_cnt_q != 16'hFFFF) xfer_cnt_d = xfer_cnt_q + 16'd1;
          if (slverr_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
          state_d = StIdle;
        end else begin
          // Hold the response until the requester completes the transfer
          ready_d  = ready_q;
          rdata_d  = rdata_q;
          slverr_d = slverr_q;
          if (apb_enable_i && (wait_cnt_q != 4'd0)) begin
            wait_cnt_d = wait_cnt_q - 4'd1;
            if (wait_cnt_q == 4'd1) begin
              ready_d  = 1'b1;
              rdata_d  = resp_rdata;
              slverr_d = resp_err;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and register bank, cleared asynchronously
  always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
    if (!apb_resetn_i) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      is_reg_q   <= 1'b0;
      is_stat_q  <= 1'b0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      strb_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      slverr_q   <= 1'b0;
      xfer_cnt_q <= '0;
      err_cnt_q  <= '0;
`ifdef APB_REGFILE_SLAVE_PROT_CHECK_EN
      prot_q     <= '0;
`endif
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      is_reg_q   <= is_reg_d;
      is_stat_q  <= is_stat_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      strb_q     <= strb_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      slverr_q   <= slverr_d;
      xfer_cnt_q <= xfer_cnt_d;
      err_cnt_q  <= err_cnt_d;
`ifdef APB_REGFILE_SLAVE_PROT_CHECK_EN
      prot_q     <= prot_d;
`endif
      for (int k = 0; k < NREGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  assign apb_ready_o  = ready_q;
  assign apb_rdata_o  = rdata_q;
  assign apb_slverr_o = slverr_q;

  for (genvar k = 0; k < NREGS; k++) begin : g_regs_out
    assign regs_o[32*k +: 32] = regs_q[k];
  end

endmodule
